// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue: turns PS/2 set-2 scan bytes into one press/release event per key action.
// Latency: the final byte of a sequence is queued at the edge ending its strobe cycle; visible next cycle.
// Backpressure: none toward the keyboard; events arriving while the queue is full are dropped and flagged.
//
// Ports:
//   clock, reset         - single clock, asynchronous active-high reset
//   scan_byte/scan_valid - received scan-code byte and its one-cycle qualifier
//   ev_pop               - consumer pops the head entry (ignored when empty)
//   ev_valid/ev_data     - queue non-empty / head entry {ext, release, code}, zero when empty
//   pixel_data_out       - head entry zero-extended to 32 bits for the processor
//   ev_count             - entries currently held
//   overflow             - sticky, set when an event was dropped because the queue was full
module ps2_key_event_queue #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    scan_byte,
    input  logic                          scan_valid,
    input  logic                          ev_pop,
    output logic                          ev_valid,
    output logic [9:0]                    ev_data,
    output logic [31:0]                   pixel_data_out,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_E0   = 3'd1,
        PRE_F0   = 3'd2,
        PRE_E0F0 = 3'd3,
        SKIP     = 3'd4
    } state_t;

    typedef struct packed {
        logic       vld;
        logic       ext;
        logic [7:0] code;
    } held_t;

    state_t         state_q, state_d;
    logic [2:0]     skip_q, skip_d;
    logic [TW-1:0]  to_q, to_d;
    held_t          held_q, held_d;

    logic           dec_vld;
    logic           dec_ext;
    logic           dec_rel;
    logic [7:0]     dec_code;
    logic           push;

    logic [AW:0]    wp_q, rp_q;
    logic [9:0]     mem_q [FIFO_DEPTH];
    logic           overflow_q;
    logic           fifo_empty;
    logic           fifo_full;
    logic           pop_eff;
    logic           push_ok;

    // Byte classification
    logic is_e0, is_f0, is_e1, is_fake, is_noise, timed_out;

    always_comb begin
        is_e0    = (scan_byte == 8'hE0);
        is_f0    = (scan_byte == 8'hF0);
        is_e1    = (scan_byte == 8'hE1);
        // E0 12 / E0 59 are the fake-shift bytes wrapped around extended keys
        is_fake  = (scan_byte == 8'h12) || (scan_byte == 8'h59);
        // Controller/keyboard responses that never represent a key
        is_noise = (scan_byte == 8'h00) || (scan_byte == 8'hAA) || (scan_byte == 8'hEE) ||
                   (scan_byte == 8'hFA) || (scan_byte == 8'hFE) || (scan_byte == 8'hFF);
        timed_out = (to_q == TW'(TIMEOUT_CYCLES));
    end

    // Decoder state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            skip_q  <= 3'd0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            to_q    <= to_d;
        end
    end

    // Decoder next state
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        // Idle counter restarts on every byte and saturates so it never wraps back under the limit
        if (scan_valid)
            to_d = '0;
        else if (timed_out)
            to_d = to_q;
        else
            to_d = to_q + TW'(1);

        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_e0)
                        state_d = PRE_E0;
                    else if (is_f0)
                        state_d = PRE_F0;
                    else if (is_e1) begin
                        // Pause is E1 followed by seven more bytes with no release
                        state_d = SKIP;
                        skip_d  = 3'd7;
                    end
                end
                PRE_E0:   state_d = is_f0 ? PRE_E0F0 : IDLE;
                PRE_F0:   state_d = IDLE;
                PRE_E0F0: state_d = IDLE;
                SKIP: begin
                    if (skip_q <= 3'd1) begin
                        state_d = IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default:  state_d = IDLE;
            endcase
        end else if (state_q != IDLE && timed_out) begin
            // Abandon a prefix whose follow-up byte never arrived
            state_d = IDLE;
            skip_d  = 3'd0;
        end
    end

    // Decoder output: raw event candidate for the current byte
    always_comb begin
        dec_vld  = 1'b0;
        dec_ext  = 1'b0;
        dec_rel  = 1'b0;
        dec_code = scan_byte;
        if (scan_valid) begin
            case (state_q)
                IDLE: dec_vld = !(is_e0 || is_f0 || is_e1 || is_noise);
                PRE_E0: begin
                    dec_vld = !(is_f0 || is_fake);
                    dec_ext = 1'b1;
                end
                PRE_F0: begin
                    dec_vld = 1'b1;
                    dec_rel = 1'b1;
                end
                PRE_E0F0: begin
                    dec_vld = !is_fake;
                    dec_ext = 1'b1;
                    dec_rel = 1'b1;
                end
                default: dec_vld = 1'b0;
            endcase
        end
    end

    // Typematic filter: a held key repeats makes until released; only the first make passes
    always_comb begin
        held_d = held_q;
        push   = 1'b0;
        if (dec_vld) begin
            if (!dec_rel) begin
                if (!(held_q.vld && held_q.ext == dec_ext && held_q.code == dec_code)) begin
                    push   = 1'b1;
                    held_d = '{vld: 1'b1, ext: dec_ext, code: dec_code};
                end
            end else begin
                push = 1'b1;
                if (held_q.ext == dec_ext && held_q.code == dec_code)
                    held_d.vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            held_q <= '0;
        else
            held_q <= held_d;
    end

    // Event FIFO: extra pointer bit distinguishes full from empty
    always_comb begin
        fifo_empty = (wp_q == rp_q);
        fifo_full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop_eff    = ev_pop && !fifo_empty;
        // A pop on a full queue frees the head slot in time for this cycle's write
        push_ok    = push && (!fifo_full || pop_eff);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wp_q[AW-1:0]] <= {dec_ext, dec_rel, dec_code};
                wp_q                <= wp_q + 1'b1;
            end
            if (pop_eff)
                rp_q <= rp_q + 1'b1;
            if (push && !push_ok)
                overflow_q <= 1'b1;
        end
    end

    always_comb begin
        ev_valid       = !fifo_empty;
        ev_data        = fifo_empty ? 10'd0 : mem_q[rp_q[AW-1:0]];
        pixel_data_out = {22'd0, ev_data};
        ev_count       = wp_q - rp_q;
        overflow       = overflow_q;
    end

endmodule
